// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small power-of-two transmit FIFO.
// The serial line is registered and follows the next FSM state, so a pop is visible on tx one edge later.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [2:0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [2:0]    CNT_FULL = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [2:0]    r_count;
  logic [7:0]    r_shift, w_shift_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic          r_tx, w_tx_next;
  logic          w_push, w_pop, w_bit_end, w_fifo_nempty;

  assign wr_ready      = (r_count != CNT_FULL);
  assign w_push        = wr_en && wr_ready;
  assign w_fifo_nempty = (r_count != 3'd0);
  assign w_bit_end     = (r_baud == BAUD_MAX);

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_baud_next  = (r_state == IDLE || w_bit_end) ? '0 : r_baud + BAUD_ONE;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fifo_nempty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_bit_next   = '0;
          w_baud_next  = '0;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_bit_next   = '0;
          w_state_next = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
            w_state_next = STOP;
          end else begin
            w_shift_next = r_shift >> 1;
            w_bit_next   = r_bit + 3'd1;
          end
        end
      end
      STOP: begin
        // Chaining straight into START keeps back-to-back frames gapless.
        if (w_bit_end) begin
          if (w_fifo_nempty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rptr];
            w_bit_next   = '0;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_baud  <= w_baud_next;
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  assign tx         = r_tx;
  assign tx_done    = (r_state == STOP) && w_bit_end;
  assign busy       = (r_state != IDLE) || w_fifo_nempty;
  assign fifo_count = r_count;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (100 MHz / 9600 baud); legal range >= 2.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; fixed power of two.
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port wr_en  input  1  push request for wr_data.
REQ-006 SHALL provide port wr_data  input  8  byte to transmit.
REQ-007 SHALL provide port wr_ready  output  1  FIFO not full; push accepted only when high.
REQ-008 SHALL provide port tx  output  1  serial line, registered, idle high.
REQ-009 SHALL provide port busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL provide port tx_done  output  1  one-cycle pulse at end of each stop bit.
REQ-011 SHALL provide port fifo_count  output  3  current FIFO occupancy, 0..4.

Function
REQ-012 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1), each bit exactly CLKS_PER_BIT cycles, frame = 10*CLKS_PER_BIT cycles.
REQ-013 SHALL accept a push on any rising edge where wr_en=1 and wr_ready=1; wr_en with wr_ready=0 is ignored, FIFO contents unchanged, no overwrite.
REQ-014 SHALL drive wr_ready = (registered fifo_count != FIFO_DEPTH); a push attempted while full is refused even if a pop occurs in the same cycle.
REQ-015 SHALL implement FIFO read/write pointers wrapping modulo FIFO_DEPTH; simultaneous push and pop leaves fifo_count unchanged.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: tx=1; if fifo_count != 0, pop head into shift register, clear bit counter and baud counter, go START.
REQ-018 START: tx=0; after CLKS_PER_BIT cycles go DATA with bit index 0.
REQ-019 DATA: tx=shift[0]; every CLKS_PER_BIT cycles shift right and increment bit index; after bit index 7 completes go STOP.
REQ-020 STOP: tx=1; on final cycle of stop bit assert tx_done for one cycle; if FIFO non-empty pop and go START directly (no idle gap), else go IDLE.
REQ-021 Latency: byte pushed into empty FIFO with FSM in IDLE at edge N -> tx=0 visible after edge N+1.
REQ-022 busy SHALL equal (state != IDLE) or (fifo_count != 0).
REQ-023 Pushes during a frame SHALL NOT disturb the frame in flight; shift register loaded only on pop.
REQ-024 Baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap; no drift across back-to-back frames.

Reset
REQ-025 On rst=0, asynchronously: state=IDLE, tx=1, busy=0, tx_done=0, fifo_count=0, wr_ready=1, pointers and counters 0.
REQ-026 Reset mid-frame SHALL abandon the frame immediately (tx high at once) and discard all FIFO contents; after release, first push starts a fresh frame per REQ-021.
REQ-027 Outputs SHALL NOT change on the clock edge at which rst is released other than by normal IDLE behaviour.

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: push 0xA5 at edge N -> tx low after N+1, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, tx_done pulse once, busy falls after 40 cycles.
REQ-029 Back-to-back: push 0x00, 0xFF on consecutive edges -> two frames with no idle gap, 80 cycles total, two tx_done pulses 40 cycles apart.
REQ-030 Full FIFO: push 6 bytes 0x01..0x06 on consecutive edges while idle -> first pops, next 4 fill FIFO, wr_ready=0 and 0x06 dropped; serial output 0x01..0x05 only.
REQ-031 Push while full and pop same cycle: fill FIFO, assert wr_en on STOP-final cycle -> push refused, fifo_count drops 4->3.
REQ-032 Reset mid-frame: push 0x3C, 0x55; assert rst=0 during DATA bit 3 -> tx=1 immediately, fifo_count=0; release, push 0x81 -> only 0x81 frame transmitted.
REQ-033 Wrap: push and drain 9 bytes (0x10..0x18) in groups of 3 -> all transmitted in order, pointers wrap correctly, fifo_count returns 0.
